pc_redirect_sequencer: RTL
==========================

// Module: pc_redirect_sequencer
// PURPOSE
//  Owns the architectural fetch PC. Consumes resolved branch/jump decisions from EX
//  (taken flag + target) and trap redirects, and drives a valid/ready fetch request to IF.
//  Tags each request with an epoch bit so IF drops responses from squashed paths.
//  Sits between EX branch resolution / trap logic and the IF stage.
// PARAMETERS
//  XLEN          32            PC width
//  RESET_VECTOR  32'h0000_0000 first fetch address after reset
//  PERF_W        32            width of taken-redirect performance counter
// PORTS
//  i_clk              in   1     clock
//  i_rst_n            in   1     asynchronous active-low reset
//  i_ex_valid         in   1     EX holds a valid instruction this cycle
//  i_branch_taken     in   1     EX branch/jump taken (qualified by i_ex_valid)
//  i_branch_target    in   XLEN  EX branch/jump target
//  i_trap_valid       in   1     trap/exception redirect request
//  i_trap_target      in   XLEN  trap handler address
//  i_stall            in   1     front-end stall: no sequential PC advance
//  i_fetch_ready      in   1     IF accepts o_fetch_pc this cycle
//  o_fetch_valid      out  1     fetch request valid
//  o_fetch_pc         out  XLEN  fetch address (registered)
//  o_fetch_epoch      out  1     epoch tag of the current request
//  o_flush            out  1     squash IF/ID this cycle (combinational)
//  o_target_misalign  out  1     accepted redirect target has bit1 set (1-cycle pulse)
//  o_redirect_count   out  PERF_W  number of accepted redirects, wraps mod 2^PERF_W
// BEHAVIOUR
//  Reset (async, i_rst_n=0): state=BOOT, o_fetch_pc=RESET_VECTOR, o_fetch_valid=0,
//   o_fetch_epoch=0, o_redirect_count=0, pending regs=0, o_target_misalign=0.
//  States: BOOT -> RUN (unconditionally, first cycle after reset release).
//   RUN -> PEND on redirect while o_fetch_valid & !i_fetch_ready.
//   PEND -> RUN on the cycle the held request is accepted (i_fetch_ready=1).
//  o_fetch_valid=1 in RUN and PEND; 0 in BOOT.
//  Redirect source: redir = i_trap_valid | (i_ex_valid & i_branch_taken).
//   Trap has priority over branch when both are asserted in the same cycle.
//   Redirect address = chosen target with bit0 cleared.
//  o_flush = redir, same cycle; independent of state and i_stall.
//  Epoch: toggles on the cycle after every accepted redirect; responses tagged
//   with the old epoch are dropped by IF.
//  Handshake: o_fetch_pc/o_fetch_epoch stay stable while o_fetch_valid & !i_fetch_ready.
//  RUN, no redirect: on accept and !i_stall, PC <= PC+4 (wraps mod 2^XLEN).
//   Otherwise PC holds.
//  RUN, redirect, request accepted or not valid: next-cycle PC = target, epoch toggled.
//   Redirect overrides i_stall.
//  RUN, redirect, request pending unaccepted: latch target into pend_pc; go to PEND.
//   PC and epoch are unchanged.
//  PEND: a new redirect overwrites pend_pc; trap still wins; no further count increment.
//   On accept: PC <= pend_pc, epoch toggles, state=RUN.
//  o_redirect_count increments once per redirect event in RUN.
//   A redirect arriving in PEND does not increment.
//  o_target_misalign: registered; set to target[1] the cycle after a redirect, else 0.
//  Redirect in BOOT: latched as pend_pc and issued as the first fetch.
//   Epoch is still 0 when that first fetch is issued.
//  Reset asserted mid-PEND: pending redirect is discarded; restart at RESET_VECTOR.
// TESTING
//  Reset release:
//   -> BOOT 1 cycle, then valid with pc=0x0, epoch=0.
//   Always-ready: pc 0x0,0x4,0x8,...
//  Taken branch, ready=1, target=0x100 at pc=0x8:
//   -> o_flush same cycle.
//   -> next pc=0x100, epoch=1, count=1.
//  ready=0 at pc=0x10 with branch to 0x200:
//   -> pc holds 0x10 in PEND.
//   -> ready=1 accepts 0x10; next pc=0x200, epoch toggles.
//  Simultaneous trap (0x80) and branch (0x300):
//   -> pc=0x80, count increments by 1.
//  JALR target 0x1006:
//   -> pc=0x1006, o_target_misalign=1 for 1 cycle.
//   i_stall=1 with no redirect: pc holds.
//  Wrap and mid-PEND reset:
//   pc=0xFFFF_FFFC accepted -> pc=0x0.
//   Reset in PEND -> pc=RESET_VECTOR, count=0.

Source files
------------

// File: rtl/pc_redirect_sequencer.sv
// Fetch PC owner: sequential advance, branch/trap redirects, epoch tagging and
// a valid/ready request toward IF that holds a redirect until the current request drains.
module pc_redirect_sequencer #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int unsigned     PERF_W       = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_ex_valid,
  input  logic              i_branch_taken,
  input  logic [XLEN-1:0]   i_branch_target,
  input  logic              i_trap_valid,
  input  logic [XLEN-1:0]   i_trap_target,
  input  logic              i_stall,
  input  logic              i_fetch_ready,
  output logic              o_fetch_valid,
  output logic [XLEN-1:0]   o_fetch_pc,
  output logic              o_fetch_epoch,
  output logic              o_flush,
  output logic              o_target_misalign,
  output logic [PERF_W-1:0] o_redirect_count
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                valid_q, valid_d;
  logic [XLEN-1:0]     pc_q, pc_d;
  logic [XLEN-1:0]     pend_pc_q, pend_pc_d;
  logic                epoch_q, epoch_d;
  logic [PERF_W-1:0]   count_q, count_d;
  logic                misalign_q, misalign_d;

  logic                redir;
  logic                accept;
  logic [XLEN-1:0]     tgt;
  logic [XLEN-1:0]     redir_addr;

  // Redirect selection: trap beats branch; bit0 of the target is never fetched.
  always_comb begin
    redir      = i_trap_valid | (i_ex_valid & i_branch_taken);
    tgt        = i_trap_valid ? i_trap_target : i_branch_target;
    redir_addr = tgt & ~XLEN'(1);
    accept     = valid_q & i_fetch_ready;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_BOOT;
      valid_q    <= 1'b0;
      pc_q       <= RESET_VECTOR;
      pend_pc_q  <= '0;
      epoch_q    <= 1'b0;
      count_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      pend_pc_q  <= pend_pc_d;
      epoch_q    <= epoch_d;
      count_q    <= count_d;
      misalign_q <= misalign_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    valid_d    = 1'b1;
    pc_d       = pc_q;
    pend_pc_d  = pend_pc_q;
    epoch_d    = epoch_q;
    count_d    = count_q;
    misalign_d = redir & tgt[1];

    unique case (state_q)
      // A redirect seen during boot becomes the first fetch, still in epoch 0.
      ST_BOOT: begin
        state_d = ST_RUN;
        if (redir) begin
          pend_pc_d = redir_addr;
          pc_d      = redir_addr;
        end
      end
      ST_RUN: begin
        if (redir) begin
          count_d = count_q + PERF_W'(1);
          if (accept) begin
            pc_d    = redir_addr;
            epoch_d = ~epoch_q;
          end else begin
            pend_pc_d = redir_addr;
            state_d   = ST_PEND;
          end
        end else if (accept && !i_stall) begin
          pc_d = pc_q + XLEN'(4);
        end
      end
      // The held request must drain first; the newest redirect wins the slot.
      ST_PEND: begin
        if (redir) begin
          pend_pc_d = redir_addr;
        end
        if (accept) begin
          pc_d    = redir ? redir_addr : pend_pc_q;
          epoch_d = ~epoch_q;
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_BOOT;
        valid_d = 1'b0;
      end
    endcase
  end

  assign o_fetch_valid     = valid_q;
  assign o_fetch_pc        = pc_q;
  assign o_fetch_epoch     = epoch_q;
  assign o_flush           = redir;
  assign o_target_misalign = misalign_q;
  assign o_redirect_count  = count_q;

endmodule
